// File: rtl/hazard_ctrl.sv
// Issue/hazard controller between decode and execute.
// Tracks per-register result latency, stalls decode on RAW hazards,
// serialises control-flow ops and flushes the front end on a taken branch.
module hazard_ctrl #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned LD_LAT  = 3,
  parameter int unsigned CNT_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    D_valid,
  input  logic [$clog2(NREG)-1:0] D_ra,
  input  logic [$clog2(NREG)-1:0] D_rb,
  input  logic [$clog2(NREG)-1:0] D_rd,
  input  logic                    D_we,
  input  logic                    D_ld,
  input  logic                    D_addi,
  input  logic                    D_brn,
  input  logic                    E_brn_res,
  input  logic                    E_brn_taken,
  output logic                    stall,
  output logic                    issue,
  output logic                    D_kill,
  output logic                    F_flush,
  output logic [NREG-1:0]         sb_busy,
  output logic                    proto_err
);

  localparam logic [CNT_W-1:0] LD_CNT  = CNT_W'(LD_LAT - 1);
  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             proto_err_q, proto_err_d;
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];

  logic             rb_used;
  logic             haz;

  // Hazard detection from the scoreboard; r0 is never tracked so it never hazards
  always_comb begin
    rb_used = ~(D_addi | D_ld);
    haz     = D_valid & ((cnt_q[D_ra] != '0) | (rb_used & (cnt_q[D_rb] != '0)));
  end

  // FSM next state and issue/stall/kill outputs; everything held low during reset
  always_comb begin
    state_d     = state_q;
    proto_err_d = proto_err_q;
    stall       = 1'b0;
    issue       = 1'b0;
    D_kill      = 1'b0;
    F_flush     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          stall  = haz;
          issue  = D_valid & ~haz;
          D_kill = D_valid & haz;
          if (D_valid & ~haz & D_brn) state_d = BR_WAIT;
          if (E_brn_res) proto_err_d = 1'b1;
        end
        BR_WAIT: begin
          stall  = 1'b1;
          D_kill = 1'b1;
          if (E_brn_res) state_d = E_brn_taken ? FLUSH : RUN;
        end
        FLUSH: begin
          F_flush = 1'b1;
          D_kill  = 1'b1;
          state_d = RUN;
          if (E_brn_res) proto_err_d = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Scoreboard update: age every live entry, then a new writer overrides its own entry
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : '0;
    end
    if (issue & D_we & (D_rd != '0)) begin
      cnt_d[D_rd] = D_ld ? LD_CNT : ALU_CNT;
    end
    cnt_d[0] = '0;
  end

  // Busy vector and sticky protocol error, both suppressed while in reset
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      sb_busy[i] = ~rst & (cnt_q[i] != '0);
    end
    proto_err = ~rst & proto_err_q;
  end

  // State, protocol-error and scoreboard registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      proto_err_q <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      proto_err_q <= proto_err_d;
      for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
